fifo_ram_ctrl: RTL and testbench
================================

// Module: fifo_ram_ctrl
// PURPOSE
//  Synchronous FIFO controller wrapped around the 64x16 dual-port RAM with registered read address.
//  Upstream producers push words. The block drives the RAM write port (we/address/DI).
//  Downstream consumers pop words. The block drives the RAM read port (DPRA) and returns DPO as rd_data.
//  Holds pointers, occupancy and flags only; all storage lives in the RAM instance.
// PARAMETERS
//  DATA_W  16  word width; must match RAM DI/DPO width
//  ADDR_W  6   RAM address width; DEPTH = 2**ADDR_W = 64 entries
// PORTS
//  CLK       in   1         clock, all state updates on posedge
//  RST       in   1         asynchronous active-high reset
//  wr_en     in   1         push request
//  wr_data   in   DATA_W    push data
//  full      out  1         no free entry; push ignored
//  rd_en     in   1         pop request
//  rd_data   out  DATA_W    popped word; valid only while rd_valid=1
//  rd_valid  out  1         one-cycle strobe, rd_data valid
//  empty     out  1         no stored entry; pop ignored
//  count     out  ADDR_W+1  occupancy, 0..DEPTH
//  ovf       out  1         sticky overflow flag (FIFO_ERR_FLAGS_EN only)
//  udf       out  1         sticky underflow flag (FIFO_ERR_FLAGS_EN only)
//  ram_we    out  1         to RAM we
//  ram_addr  out  ADDR_W    to RAM address (write pointer)
//  ram_di    out  DATA_W    to RAM DI
//  ram_dpra  out  ADDR_W    to RAM DPRA (read pointer)
//  ram_dpo   in   DATA_W    from RAM DPO
// BEHAVIOUR
//  Reset (async, RST=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, ovf=0, udf=0.
//   RAM contents are not cleared. Reset mid-operation flushes the FIFO; no rd_valid follows.
//  Accept rules use flag values sampled before the edge:
//   push_ok = wr_en & ~full; pop_ok = rd_en & ~empty.
//  Write path (combinational): ram_we=push_ok, ram_addr=wr_ptr, ram_di=wr_data.
//   On push_ok, wr_ptr <= wr_ptr+1 (mod DEPTH, natural wrap 63->0).
//  Read path: ram_dpra=rd_ptr (combinational). RAM registers DPRA on the same edge that accepts the pop.
//   On pop_ok at edge N: rd_ptr <= rd_ptr+1 (mod DEPTH); rd_valid=1 during cycle N..N+1.
//   rd_data = ram_dpo (pass-through). Latency is 1 cycle from accepting edge to valid data.
//   Back-to-back pops give one word per cycle.
//  count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   full = (count==DEPTH); empty = (count==0). Both registered, updated on the same edge as count.
//  Simultaneous events:
//   - Full with push and pop: pop accepted, push dropped; count=DEPTH-1 after the edge.
//   - Empty with push and pop: push accepted, pop ignored (no fall-through); count=1, rd_valid=0.
//   - Otherwise both are accepted.
//  Write-to-read: a word pushed at edge N is poppable at edge N+1 (empty falls after N).
//   Its data is valid after edge N+1.
//  Pointer wrap needs no special handling; count disambiguates full from empty.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//   - ovf set on wr_en&full; udf set on rd_en&empty.
//   - Both are sticky until RST; error events never change pointers or count.
//  FIFO_ERR_FLAGS_EN undefined:
//   - ovf and udf are tied to 0; no flag registers are built.
//   - All other behaviour is identical.
// TESTING
//  1 Reset: assert RST mid-stream with count=5 -> count=0, empty=1, full=0, rd_valid=0 immediately (async).
//  2 Push 0x0001..0x0040 (64 words) -> full=1, count=64; 65th push -> ram_we=0, count stays 64;
//    ovf=1 only with FIFO_ERR_FLAGS_EN.
//  3 Drain 64 pops back-to-back -> rd_data sequence 0x0001..0x0040, one per cycle, 1-cycle latency;
//    empty=1 after the last pop; an extra pop -> rd_valid=0 (udf=1 only with the macro).
//  4 Simultaneous ops:
//    - Full + push 0xBEEF + pop -> count=63, 0xBEEF not written.
//    - Empty + push 0x1234 + pop -> count=1, rd_valid=0; next pop returns 0x1234.
//  5 Wrap: 100 cycles of streaming push+pop at count=10 -> pointers wrap 63->0;
//    data order preserved; count constant at 10.

Source files
------------

// File: rtl/fifo_ram_ctrl_if.sv
// fifo_ram_ctrl_if: producer/consumer handshake plus the RAM port bundle
// for fifo_ram_ctrl. The slave modport is the controller.
// The master modport is the surrounding environment: the clients and the RAM.
interface fifo_ram_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
);
    // push side
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    // pop side
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    // status
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              udf;
    // RAM write port
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    // RAM read port (read address registered inside the RAM)
    logic [ADDR_W-1:0] ram_dpra;
    logic [DATA_W-1:0] ram_dpo;

    modport master (
        output wr_en, wr_data, rd_en, ram_dpo,
        input  full, rd_data, rd_valid, empty, count, ovf, udf,
               ram_we, ram_addr, ram_di, ram_dpra
    );

    modport slave (
        input  wr_en, wr_data, rd_en, ram_dpo,
        output full, rd_data, rd_valid, empty, count, ovf, udf,
               ram_we, ram_addr, ram_di, ram_dpra
    );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: synchronous FIFO controller around a 2**ADDR_W x DATA_W
// dual-port RAM whose read address is registered inside the RAM.
// The block holds only the pointers, the occupancy and the flags.
// Optional macro FIFO_ERR_FLAGS_EN builds sticky overflow/underflow flags.
// Without the macro, ovf and udf are tied low.
module fifo_ram_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_ram_ctrl_if.slave    bus
);
    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              rd_valid_q, rd_valid_d;
    logic              push_ok;
    logic              pop_ok;

    // Accept decisions use the registered flags from before the edge.
    always_comb begin
        push_ok = bus.wr_en & ~full_q;
        pop_ok  = bus.rd_en & ~empty_q;
    end

    // Next-state for the pointers, the occupancy, the flags and the read strobe.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = pop_ok;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH);
        empty_d = (count_d == '0);
    end

    // State registers; reset flushes the FIFO but leaves the RAM contents alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // The RAM captures ram_dpra on the accepting edge, so ram_dpo holds the popped word one cycle later.
    assign bus.ram_we   = push_ok;
    assign bus.ram_addr = wr_ptr_q;
    assign bus.ram_di   = bus.wr_data;
    assign bus.ram_dpra = rd_ptr_q;
    assign bus.rd_data  = bus.ram_dpo;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A rejected request sets its flag, and the flag stays set until reset.
    always_comb begin
        ovf_d = ovf_q | (bus.wr_en & full_q);
        udf_d = udf_q | (bus.rd_en & empty_q);
    end

    // Sticky error flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`else
    assign bus.ovf = 1'b0;
    assign bus.udf = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb_fifo_ram_ctrl: self-checking bench for fifo_ram_ctrl with a behavioural
// 64x16 registered-read-address RAM and a queue-based reference model.
module tb_fifo_ram_ctrl;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fifo_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // RAM: synchronous write, read address registered, asynchronous data out.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] dpra_q;
    always @(posedge CLK) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
        dpra_q <= bus.ram_dpra;
    end
    assign bus.ram_dpo = mem[dpra_q];

    // Reference model
    logic [DW-1:0] q[$];
    int            wr_tot, rd_tot;
    bit            ovf_m, udf_m;
    bit            exp_we, exp_valid, exp_full, exp_empty;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_cnt;
    logic [AW-1:0] exp_addr, exp_dpra;
    logic          obs_we;
    logic [AW-1:0] obs_addr, obs_dpra;

    function automatic bit exp_ovf();
`ifdef FIFO_ERR_FLAGS_EN
        return ovf_m;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_udf();
`ifdef FIFO_ERR_FLAGS_EN
        return udf_m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        q.delete();
        wr_tot = 0; rd_tot = 0; ovf_m = 0; udf_m = 0;
        exp_valid = 0; exp_cnt = '0; exp_full = 0; exp_empty = 1;
    endtask

    // Drive one cycle from a negedge, sample combinational outputs, advance the model.
    task automatic drive_cycle(input bit wr, input logic [DW-1:0] wd, input bit rd);
        bit push, pop;
        bus.wr_en = wr; bus.wr_data = wd; bus.rd_en = rd;
        #1;
        obs_we = bus.ram_we; obs_addr = bus.ram_addr; obs_dpra = bus.ram_dpra;
        push = wr && (q.size() < DEPTH);
        pop  = rd && (q.size() != 0);
        if (wr && q.size() == DEPTH) ovf_m = 1;
        if (rd && q.size() == 0)     udf_m = 1;
        exp_we = push; exp_addr = AW'(wr_tot); exp_dpra = AW'(rd_tot);
        @(posedge CLK);
        exp_valid = pop;
        if (pop)  begin exp_data = q.pop_front(); rd_tot++; end
        if (push) begin q.push_back(wd); wr_tot++; end
        exp_cnt   = (AW+1)'(q.size());
        exp_full  = (q.size() == DEPTH);
        exp_empty = (q.size() == 0);
        @(negedge CLK);
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.rd_en = 0; bus.wr_data = '0;
    endtask

    task automatic test_reset();
        idle();
        model_clear();
        RST = 1'b1;
        #12;
        n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        n_checks++; if ({bus.ovf, bus.udf} !== 2'b00) begin n_fail++; $display("FAIL reset_errflags got %b%b exp 00", bus.ovf, bus.udf); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, DW'($urandom), 1'b0);
        drive_cycle(1'b0, '0, 1'b1);
        n_checks++; if (bus.count !== exp_cnt) begin n_fail++; $display("FAIL midrst_pre_count got %0d exp %0d", bus.count, exp_cnt); end
        n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b exp 1", bus.rd_valid); end
        #2 RST = 1'b1;
        #1;
        n_checks++; if (bus.count !== '0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got %b exp 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL midrst_full got %b exp 0", bus.full); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", bus.rd_valid); end
        idle();
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        drive_cycle(1'b0, '0, 1'b0);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after_valid got %b exp 0", bus.rd_valid); end
        n_checks++; if (bus.ram_dpra !== '0) begin n_fail++; $display("FAIL midrst_rdptr got %0d exp 0", bus.ram_dpra); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 64; i++) begin
            drive_cycle(1'b1, DW'(i), 1'b0);
            n_checks++; if (obs_we !== exp_we || obs_addr !== exp_addr) begin n_fail++; $display("FAIL fill_wr[%0d] got we=%b addr=%0d exp we=%b addr=%0d", i, obs_we, obs_addr, exp_we, exp_addr); end
            n_checks++; if (bus.count !== exp_cnt || bus.full !== exp_full || bus.empty !== exp_empty) begin n_fail++; $display("FAIL fill_state[%0d] got cnt=%0d f=%b e=%b exp cnt=%0d f=%b e=%b", i, bus.count, bus.full, bus.empty, exp_cnt, exp_full, exp_empty); end
        end
        drive_cycle(1'b1, 16'hDEAD, 1'b0);
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL fill_overflow_we got %b exp 0", obs_we); end
        n_checks++; if (bus.count !== 7'd64 || bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_state got cnt=%0d f=%b exp cnt=64 f=1", bus.count, bus.full); end
        n_checks++; if (bus.ovf !== exp_ovf()) begin n_fail++; $display("FAIL fill_ovf got %b exp %b", bus.ovf, exp_ovf()); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 64; i++) begin
            drive_cycle(1'b0, '0, 1'b1);
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data) begin n_fail++; $display("FAIL drain_data[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp_data); end
            n_checks++; if (bus.count !== exp_cnt || bus.empty !== exp_empty || bus.full !== exp_full) begin n_fail++; $display("FAIL drain_state[%0d] got cnt=%0d e=%b f=%b exp cnt=%0d e=%b f=%b", i, bus.count, bus.empty, bus.full, exp_cnt, exp_empty, exp_full); end
        end
        drive_cycle(1'b0, '0, 1'b1);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_extra_valid got %b exp 0", bus.rd_valid); end
        n_checks++; if (bus.count !== '0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_extra_state got cnt=%0d e=%b exp cnt=0 e=1", bus.count, bus.empty); end
        n_checks++; if (bus.udf !== exp_udf()) begin n_fail++; $display("FAIL drain_udf got %b exp %b", bus.udf, exp_udf()); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 64; i++) drive_cycle(1'b1, DW'($urandom), 1'b0);
        drive_cycle(1'b1, 16'hBEEF, 1'b1);
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL simfull_we got %b exp 0", obs_we); end
        n_checks++; if (bus.count !== 7'd63 || bus.full !== 1'b0) begin n_fail++; $display("FAIL simfull_state got cnt=%0d f=%b exp cnt=63 f=0", bus.count, bus.full); end
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data) begin n_fail++; $display("FAIL simfull_data got v=%b d=%h exp v=1 d=%h", bus.rd_valid, bus.rd_data, exp_data); end
        for (int i = 0; i < 63; i++) begin
            drive_cycle(1'b0, '0, 1'b1);
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data) begin n_fail++; $display("FAIL simfull_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp_data); end
        end
        drive_cycle(1'b1, 16'h1234, 1'b1);
        n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL simempty_we got %b exp 1", obs_we); end
        n_checks++; if (bus.count !== 7'd1 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL simempty_state got cnt=%0d v=%b e=%b exp cnt=1 v=0 e=0", bus.count, bus.rd_valid, bus.empty); end
        drive_cycle(1'b0, '0, 1'b1);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1234) begin n_fail++; $display("FAIL simempty_pop got v=%b d=%h exp v=1 d=1234", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_wrap();
        bit wrapped = 0;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 100; i++) begin
            drive_cycle(1'b1, DW'($urandom), 1'b1);
            if (obs_addr == '0 || obs_dpra == '0) wrapped = 1;
            n_checks++; if (obs_addr !== exp_addr || obs_dpra !== exp_dpra) begin n_fail++; $display("FAIL wrap_ptr[%0d] got wa=%0d ra=%0d exp wa=%0d ra=%0d", i, obs_addr, obs_dpra, exp_addr, exp_dpra); end
            n_checks++; if (bus.count !== 7'd10) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp 10", i, bus.count); end
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_data) begin n_fail++; $display("FAIL wrap_data[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp_data); end
        end
        n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_seen got %b exp 1", wrapped); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive_cycle(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45));
            n_checks++; if (obs_we !== exp_we || obs_addr !== exp_addr || obs_dpra !== exp_dpra) begin n_fail++; $display("FAIL rand_ram[%0d] got we=%b wa=%0d ra=%0d exp we=%b wa=%0d ra=%0d", i, obs_we, obs_addr, obs_dpra, exp_we, exp_addr, exp_dpra); end
            n_checks++; if (bus.count !== exp_cnt || bus.full !== exp_full || bus.empty !== exp_empty) begin n_fail++; $display("FAIL rand_state[%0d] got cnt=%0d f=%b e=%b exp cnt=%0d f=%b e=%b", i, bus.count, bus.full, bus.empty, exp_cnt, exp_full, exp_empty); end
            n_checks++; if (bus.rd_valid !== exp_valid || (exp_valid && bus.rd_data !== exp_data)) begin n_fail++; $display("FAIL rand_read[%0d] got v=%b d=%h exp v=%b d=%h", i, bus.rd_valid, bus.rd_data, exp_valid, exp_data); end
            n_checks++; if (bus.ovf !== exp_ovf() || bus.udf !== exp_udf()) begin n_fail++; $display("FAIL rand_errflags[%0d] got %b%b exp %b%b", i, bus.ovf, bus.udf, exp_ovf(), exp_udf()); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_reset_mid();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_random();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
